// File: rtl/gearbox_67_20_duplex.sv
// Duplex 67b/20b gearbox. TX packs sparse 67-bit blocks into a continuous 20-bit lane.
// RX unpacks the lane into 67-bit blocks and can bit-slip until the block header is legal.
module gearbox_67_20_duplex (
  input  logic        clk,
  input  logic        arst,
  input  logic [66:0] tx_din,
  input  logic        tx_din_valid,
  output logic [19:0] tx_dout,
  input  logic [19:0] rx_din,
  input  logic        rx_slip_to_frame,
  output logic [66:0] rx_dout,
  output logic        rx_dout_valid
);

  logic [133:0] tx_buf_q, tx_buf_d, tx_buf_app;
  logic [7:0]   tx_cnt_q, tx_cnt_d, tx_cnt_app;
  logic [19:0]  tx_dout_q, tx_dout_d;

  // NOTE: every signal written here gets a default before any branch, so no latch can be inferred.
  always_comb begin
    tx_buf_app = tx_buf_q;
    tx_cnt_app = tx_cnt_q;
    tx_buf_d   = '0;
    tx_cnt_d   = '0;
    if (tx_din_valid && (tx_cnt_q <= 8'd67)) begin
      tx_buf_app = tx_buf_q | ({67'b0, tx_din} << tx_cnt_q);
      tx_cnt_app = tx_cnt_q + 8'd67;
    end
    // Bits above the count are always zero, so an underflow word comes out zero-padded.
    tx_dout_d = tx_buf_app[19:0];
    if (tx_cnt_app >= 8'd20) begin
      tx_buf_d = tx_buf_app >> 20;
      tx_cnt_d = tx_cnt_app - 8'd20;
    end
  end

  logic [87:0] rx_buf_q, rx_buf_d, rx_kept;
  logic [6:0]  rx_cnt_q, rx_cnt_d, rx_drop, rx_kept_cnt;
  logic [66:0] rx_cand, rx_dout_q, rx_dout_d;
  logic        rx_hdr_bad, rx_valid_q, rx_valid_d;

  always_comb begin
    rx_cand    = rx_buf_q[66:0];
    rx_hdr_bad = (rx_cand[65:64] == 2'b00) || (rx_cand[65:64] == 2'b11);
    rx_drop    = '0;
    rx_dout_d  = rx_dout_q;
    rx_valid_d = 1'b0;
    if (rx_cnt_q >= 7'd67) begin
      if (!rx_slip_to_frame || !rx_hdr_bad) begin
        rx_dout_d  = rx_cand;
        rx_valid_d = 1'b1;
        rx_drop    = 7'd67;
      end else if (rx_cnt_q >= 7'd68) begin
        // Drop the bad candidate plus one bit: a one-bit alignment slip.
        rx_drop = 7'd68;
      end
    end
    rx_kept     = rx_buf_q >> rx_drop;
    rx_kept_cnt = rx_cnt_q - rx_drop;
    rx_buf_d    = rx_kept | ({68'b0, rx_din} << rx_kept_cnt);
    rx_cnt_d    = rx_kept_cnt + 7'd20;
  end

  // NOTE: the bit buffers are reset too, not just the counts; zero fill above the count is relied on.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tx_buf_q   <= '0;
      tx_cnt_q   <= '0;
      tx_dout_q  <= '0;
      rx_buf_q   <= '0;
      rx_cnt_q   <= '0;
      rx_dout_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      tx_buf_q   <= tx_buf_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_dout_q  <= tx_dout_d;
      rx_buf_q   <= rx_buf_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_dout_q  <= rx_dout_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_dout       = tx_dout_q;
  assign rx_dout       = rx_dout_q;
  assign rx_dout_valid = rx_valid_q;

endmodule

// File: tb/tb_gearbox_67_20_duplex.sv
// Bench for gearbox_67_20_duplex: instance a exercises TX packing, RX no-frame and slip hunt;
// instance b receives a's TX lane (reset released one cycle later) for loopback.
module tb_gearbox_67_20_duplex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_a, arst_b;
  logic [66:0] tx_din_a, tx_din_b;
  logic        tx_din_valid_a, tx_din_valid_b;
  logic [19:0] tx_dout_a, tx_dout_b, rx_din_a;
  logic        rx_slip_a, rx_slip_b;
  logic [66:0] rx_dout_a, rx_dout_b;
  logic        rx_valid_a, rx_valid_b;

  gearbox_67_20_duplex u_dut_a (
    .clk              (clk),
    .arst             (arst_a),
    .tx_din           (tx_din_a),
    .tx_din_valid     (tx_din_valid_a),
    .tx_dout          (tx_dout_a),
    .rx_din           (rx_din_a),
    .rx_slip_to_frame (rx_slip_a),
    .rx_dout          (rx_dout_a),
    .rx_dout_valid    (rx_valid_a)
  );

  gearbox_67_20_duplex u_dut_b (
    .clk              (clk),
    .arst             (arst_b),
    .tx_din           (tx_din_b),
    .tx_din_valid     (tx_din_valid_b),
    .tx_dout          (tx_dout_b),
    .rx_din           (tx_dout_a),
    .rx_slip_to_frame (rx_slip_b),
    .rx_dout          (rx_dout_b),
    .rx_dout_valid    (rx_valid_b)
  );

  localparam logic [0:66] SCHED =
    67'b1001001000100100100010010010001001001000100100100010010010001001000;
  localparam int PERIODS = 100;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [66:0] make_blk(input int k);
    logic [63:0] pay;
    logic [1:0]  hdr;
    logic        flag;
    if (k == 0) return {3'b010, 64'h1234167812345670};
    if (k == 1) return {3'b010, 64'h2bcd2f12abcdef12};
    pay  = {$urandom, $urandom};
    hdr  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    flag = 1'($urandom_range(0, 1));
    return {flag, hdr, pay};
  endfunction

  bit          tx_q[$];
  logic [66:0] lb_q[$];
  bit          sq[$];
  logic [66:0] slip_q[$];

  initial begin
    logic [66:0] blk;
    logic [19:0] w;
    int          drops, underflows, lb_sent, lb_rcv, win_cnt, slip_rcv, k;

    arst_a = 1'b1;  arst_b = 1'b1;
    tx_din_a = '0;  tx_din_valid_a = 1'b0;
    tx_din_b = '0;  tx_din_valid_b = 1'b0;
    rx_din_a = '0;  rx_slip_a = 1'b0;  rx_slip_b = 1'b1;
    tick();
    tick();
    check("rst_tx_dout_a", 67'(tx_dout_a), 67'(0));
    check("rst_rx_dout_a", rx_dout_a, 67'(0));
    check("rst_rx_valid_a", 67'(rx_valid_a), 67'(0));
    check("rst_rx_valid_b", 67'(rx_valid_b), 67'(0));
    arst_a = 1'b0;

    // Single block, then idle: three full words, one underflow word, then zeros.
    blk = 67'h2_1234167812345670;
    tx_din_a = blk;  tx_din_valid_a = 1'b1;
    tick();
    tx_din_valid_a = 1'b0;
    check("single_w0", 67'(tx_dout_a), 67'(blk[19:0]));
    tick();
    check("single_w1", 67'(tx_dout_a), 67'(blk[39:20]));
    tick();
    check("single_w2", 67'(tx_dout_a), 67'(blk[59:40]));
    tick();
    check("single_underflow", 67'(tx_dout_a), 67'({13'b0, blk[66:60]}));
    tick();
    check("single_idle", 67'(tx_dout_a), 67'(0));

    // Reference schedule on a's TX, looped back into b's RX; a's RX runs no-frame on zeros.
    arst_a = 1'b1;
    #2 arst_a = 1'b0;
    drops = 0;  underflows = 0;  lb_sent = 0;  lb_rcv = 0;  win_cnt = 0;  k = 0;
    for (int n = 0; n < PERIODS * 67 + 40; n++) begin
      tx_din_valid_a = 1'b0;
      if (n < PERIODS * 67 && SCHED[n % 67]) begin
        blk = make_blk(k);
        k++;
        tx_din_a = blk;
        tx_din_valid_a = 1'b1;
        if (tx_q.size() <= 67) begin
          for (int b = 0; b < 67; b++) tx_q.push_back(blk[b]);
          lb_q.push_back(blk);
          lb_sent++;
        end else begin
          drops++;
        end
      end
      tick();
      if (n == 0) arst_b = 1'b0;
      if (n < PERIODS * 67 && tx_q.size() < 20) underflows++;
      w = '0;
      for (int b = 0; b < 20; b++) if (tx_q.size() > 0) w[b] = tx_q.pop_front();
      check("tx_word", 67'(tx_dout_a), 67'(w));
      if (rx_valid_b) begin
        if (lb_q.size() > 0) begin
          check("lb_block", rx_dout_b, lb_q.pop_front());
          lb_rcv++;
        end else begin
          check("lb_extra_valid", 67'(rx_valid_b), 67'(0));
        end
      end
      if (n >= 67 && n < PERIODS * 67) begin
        if (rx_valid_a) begin
          win_cnt++;
          check("nf_zero_block", rx_dout_a, 67'(0));
        end
        if ((n - 67) % 67 == 66) begin
          check("nf_rate", 67'(win_cnt), 67'(20));
          win_cnt = 0;
        end
      end
    end
    check("sched_drops", 67'(drops), 67'(0));
    check("sched_underflows", 67'(underflows), 67'(0));
    check("lb_sent", 67'(lb_sent), 67'(PERIODS * 20));
    check("lb_received", 67'(lb_rcv), 67'(lb_sent));

    // Slip hunt: 5 leading bits, then blocks whose misaligned header windows all read 00.
    arst_a = 1'b1;
    #2 arst_a = 1'b0;
    rx_slip_a = 1'b1;
    for (int b = 0; b < 5; b++) sq.push_back(1'b0);
    for (int j = 0; j < 40; j++) begin
      blk = {1'($urandom_range(0, 1)), 2'b10, {$urandom, $urandom} & 64'h07FF_FFFF_FFFF_FFFF};
      for (int b = 0; b < 67; b++) sq.push_back(blk[b]);
      if (j >= 5) slip_q.push_back(blk);
    end
    slip_rcv = 0;
    for (int n = 0; n < 180; n++) begin
      w = '0;
      for (int b = 0; b < 20; b++) if (sq.size() > 0) w[b] = sq.pop_front();
      rx_din_a = w;
      tick();
      if (rx_valid_a) begin
        if (slip_q.size() > 0) begin
          check("slip_block", rx_dout_a, slip_q.pop_front());
          slip_rcv++;
        end else begin
          check("slip_extra_valid", 67'(rx_valid_a), 67'(0));
        end
      end
    end
    check("slip_received", 67'(slip_rcv), 67'(35));
    rx_din_a = '0;
    rx_slip_a = 1'b0;

    // Mid-stream reset: outputs clear immediately, both paths restart empty.
    blk = 67'h2_1234167812345670;
    tx_din_a = blk;  tx_din_valid_a = 1'b1;
    tick();
    tx_din_valid_a = 1'b0;
    check("pre_rst_tx_word", 67'(tx_dout_a), 67'(blk[19:0]));
    #2 arst_a = 1'b1;
    #1;
    check("mid_rst_tx_dout", 67'(tx_dout_a), 67'(0));
    check("mid_rst_rx_dout", rx_dout_a, 67'(0));
    check("mid_rst_rx_valid", 67'(rx_valid_a), 67'(0));
    #1 arst_a = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("post_rst_tx_dout", 67'(tx_dout_a), 67'(0));
      check("post_rst_rx_valid", 67'(rx_valid_a), 67'(n == 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
